// File: rtl/tmds_align_pkg.sv
// Shared TMDS word-alignment definitions.
// Control tokens, alignment FSM states and slip modulus.
package tmds_align_pkg;

  localparam logic [9:0] CTRL_TOK0 = 10'h354;
  localparam logic [9:0] CTRL_TOK1 = 10'h0AB;
  localparam logic [9:0] CTRL_TOK2 = 10'h154;
  localparam logic [9:0] CTRL_TOK3 = 10'h2AB;

  localparam int unsigned SLIP_MOD = 10;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    SETTLE,
    LOCKED
  } align_state_t;

  function automatic logic is_ctrl_tok(input logic [9:0] w);
    return (w == CTRL_TOK0) || (w == CTRL_TOK1) ||
           (w == CTRL_TOK2) || (w == CTRL_TOK3);
  endfunction

endpackage

// File: rtl/tmds_word_align_ctrl.sv
// Per-channel TMDS word-alignment control loop.
// Hunts control-token runs, drives bitslip, tracks lock.
module tmds_word_align_ctrl
  import tmds_align_pkg::*;
#(
  parameter int WIN_CYCLES    = 4096,
  parameter int TOKEN_RUN     = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOSS_WINS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data_in,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_cnt,
  output logic       align_fail
);

  localparam int WW = $clog2(WIN_CYCLES);
  localparam int RW = $clog2(TOKEN_RUN + 1);
  localparam int MW = $clog2(LOSS_WINS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES);

  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYCLES - 1);
  localparam logic [RW-1:0] RUN_FULL  = RW'(TOKEN_RUN);
  localparam logic [MW-1:0] MISS_FULL = MW'(LOSS_WINS);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    SLIP_LAST = 4'(SLIP_MOD - 1);

  // The aligner needs 4 cycles before a slip shows on data_in.
  if (SETTLE_CYCLES < 4) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 4");
  end
  if (WIN_CYCLES < 2) begin : g_bad_win
    $error("WIN_CYCLES must be at least 2");
  end
  if (TOKEN_RUN < 1 || LOSS_WINS < 1) begin : g_bad_run
    $error("TOKEN_RUN and LOSS_WINS must be positive");
  end

  align_state_t  state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [RW-1:0] run_q, run_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [SW-1:0] set_q, set_d;
  logic [3:0]    slip_q, slip_d;
  logic          bs_q, bs_d;
  logic          lock_q, lock_d;
  logic          fail_q, fail_d;

  logic          tok;
  logic [RW-1:0] run_step;
  logic          run_hit;
  logic          win_end;
  logic [WW-1:0] win_step;
  logic [MW-1:0] miss_inc;

  always_comb begin
    tok      = is_ctrl_tok(data_in);
    run_step = '0;
    if (tok) begin
      run_step = (run_q == RUN_FULL) ? run_q : run_q + 1'b1;
    end
    run_hit  = (run_step == RUN_FULL);
    win_end  = (win_q == WIN_LAST);
    win_step = win_end ? '0 : win_q + 1'b1;
    miss_inc = miss_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    run_d   = run_q;
    miss_d  = miss_q;
    set_d   = set_q;
    slip_d  = slip_q;
    bs_d    = 1'b0;
    lock_d  = lock_q;
    fail_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        run_d = run_step;
        win_d = win_step;
        if (run_hit) begin
          state_d = LOCKED;
          lock_d  = 1'b1;
          win_d   = '0;
          miss_d  = '0;
        end else if (win_end) begin
          state_d = SLIP;
          bs_d    = 1'b1;
          run_d   = '0;
          win_d   = '0;
          slip_d  = (slip_q == SLIP_LAST) ? '0 : slip_q + 1'b1;
          fail_d  = (slip_q == SLIP_LAST);
        end
      end
      SLIP: begin
        state_d = SETTLE;
        run_d   = '0;
        set_d   = '0;
      end
      SETTLE: begin
        run_d = '0;
        if (set_q == SET_LAST) begin
          state_d = SEARCH;
          win_d   = '0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      LOCKED: begin
        run_d = run_step;
        win_d = win_step;
        if (run_hit) begin
          win_d  = '0;
          miss_d = '0;
        end else if (win_end) begin
          if (miss_inc == MISS_FULL) begin
            state_d = SEARCH;
            lock_d  = 1'b0;
            miss_d  = '0;
          end else begin
            miss_d = miss_inc;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      win_q   <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      set_q   <= '0;
      slip_q  <= '0;
      bs_q    <= 1'b0;
      lock_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      set_q   <= set_d;
      slip_q  <= slip_d;
      bs_q    <= bs_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  assign bitslip    = bs_q;
  assign locked     = lock_q;
  assign slip_cnt   = slip_q;
  assign align_fail = fail_q;

endmodule
